// File: rtl/beat_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | beat_sequencer_if : command/level inputs and beat outputs of beat_sequencer |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
interface beat_sequencer_if;
  logic       play;
  logic       pause;
  logic       stop;
  logic       loop_en;
  logic [1:0] tempo;
  logic       reverse;
  logic [7:0] ibeat;
  logic       beat_tick;
  logic       playing;
  logic       done;

  modport master (
    output play, pause, stop, loop_en, tempo, reverse,
    input  ibeat, beat_tick, playing, done
  );

  modport slave (
    input  play, pause, stop, loop_en, tempo, reverse,
    output ibeat, beat_tick, playing, done
  );
endinterface
`default_nettype wire

// File: rtl/beat_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | beat_sequencer : single-clock beat-index sequencer with play/pause/stop,    |
// | loop and tempo control. Optional backward playback under REVERSE_EN.        |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module beat_sequencer #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BEAT_FREQ = 8,
  parameter int unsigned BEAT_LEN  = 128
) (
  input  wire logic           clk,
  input  wire logic           reset,
  beat_sequencer_if.slave     bus
);

  localparam int unsigned P  = CLK_FREQ / BEAT_FREQ;
  localparam int unsigned CW = (2 * P > 1) ? $clog2(2 * P) : 1;

  localparam logic [CW-1:0] PC_NORM_M1 = CW'(P - 1);
  localparam logic [CW-1:0] PC_FAST_M1 = CW'(P / 2 - 1);
  localparam logic [CW-1:0] PC_SLOW_M1 = CW'(2 * P - 1);
  localparam logic [7:0]    LAST_BEAT  = 8'(BEAT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      ibeat_q, ibeat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      tempo_q, tempo_d;
  logic            tick_q, tick_d;
  logic            playing_q, done_q;
  logic [CW-1:0]   pc_m1_w;
  logic            w_rev;

`ifdef REVERSE_EN
  assign w_rev = bus.reverse;
`else
  assign w_rev = 1'b0 & bus.reverse;
`endif

  always_comb begin
    case (tempo_q)
      2'b01:   pc_m1_w = PC_FAST_M1;
      2'b10:   pc_m1_w = PC_SLOW_M1;
      default: pc_m1_w = PC_NORM_M1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ibeat_d = ibeat_q;
    cnt_d   = cnt_q;
    tempo_d = tempo_q;
    tick_d  = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      ibeat_d = 8'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (!bus.pause && bus.play) begin
            state_d = PLAY;
            ibeat_d = w_rev ? LAST_BEAT : 8'd0;
            cnt_d   = '0;
            tempo_d = bus.tempo;
          end
        end
        PLAY: begin
          if (bus.pause) begin
            // Pause beats a pending wrap: cnt stays at Pc-1 so the tick fires after resume.
            state_d = PAUSE;
          end else if (cnt_q == pc_m1_w) begin
            cnt_d   = '0;
            tick_d  = 1'b1;
            tempo_d = bus.tempo;
            if (w_rev) begin
              if (ibeat_q != 8'd0)   ibeat_d = ibeat_q - 8'd1;
              else if (bus.loop_en)  ibeat_d = LAST_BEAT;
              else                   state_d = DONE;
            end else begin
              if (ibeat_q != LAST_BEAT) ibeat_d = ibeat_q + 8'd1;
              else if (bus.loop_en)     ibeat_d = 8'd0;
              else                      state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PAUSE: begin
          if (!bus.pause && bus.play) state_d = PLAY;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ibeat_q   <= 8'd0;
      cnt_q     <= '0;
      tempo_q   <= 2'b00;
      tick_q    <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ibeat_q   <= ibeat_d;
      cnt_q     <= cnt_d;
      tempo_q   <= tempo_d;
      tick_q    <= tick_d;
      playing_q <= (state_d == PLAY);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.ibeat     = ibeat_q;
  assign bus.beat_tick = tick_q;
  assign bus.playing   = playing_q;
  assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_beat_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_beat_sequencer : directed self-checking bench, P=10, BEAT_LEN=4          |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_beat_sequencer;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  beat_sequencer_if bus_if ();

  beat_sequencer #(
    .CLK_FREQ  (80),
    .BEAT_FREQ (8),
    .BEAT_LEN  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_play();
    bus_if.play = 1'b1; step(1); bus_if.play = 1'b0;
  endtask

  task automatic pulse_pause();
    bus_if.pause = 1'b1; step(1); bus_if.pause = 1'b0;
  endtask

  task automatic pulse_stop();
    bus_if.stop = 1'b1; step(1); bus_if.stop = 1'b0;
  endtask

  // Expects an idle beat tick for n-1 cycles, then a tick landing on beat exp_beat.
  task automatic expect_beat(input string tag, input int n, input logic [7:0] exp_beat);
    step(n - 1);
    chk({tag, "_pre_tick"}, 32'(bus_if.beat_tick), 32'd0);
    step(1);
    chk({tag, "_tick"}, 32'(bus_if.beat_tick), 32'd1);
    chk({tag, "_ibeat"}, 32'(bus_if.ibeat), 32'(exp_beat));
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b0;
    bus_if.play = 1'b0; bus_if.pause = 1'b0; bus_if.stop = 1'b0;
    bus_if.loop_en = 1'b0; bus_if.tempo = 2'b00; bus_if.reverse = 1'b0;

    // 1: reset and quiet idle
    step(3);
    reset = 1'b1;
    step(1);
    chk("rst_ibeat",   32'(bus_if.ibeat),     32'd0);
    chk("rst_tick",    32'(bus_if.beat_tick), 32'd0);
    chk("rst_playing", 32'(bus_if.playing),   32'd0);
    chk("rst_done",    32'(bus_if.done),      32'd0);
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("idle_outs", {bus_if.ibeat, 21'd0, bus_if.beat_tick, bus_if.playing, bus_if.done}, 32'd0);
    end

    // 2: single pass, no loop
    pulse_play();
    chk("s2_playing", 32'(bus_if.playing), 32'd1);
    chk("s2_ibeat0",  32'(bus_if.ibeat),   32'd0);
    expect_beat("s2_b1", 10, 8'd1);
    expect_beat("s2_b2", 10, 8'd2);
    expect_beat("s2_b3", 10, 8'd3);
    step(10);
    chk("s2_done",       32'(bus_if.done),    32'd1);
    chk("s2_not_play",   32'(bus_if.playing), 32'd0);
    chk("s2_hold_ibeat", 32'(bus_if.ibeat),   32'd3);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("s2_no_tick", 32'(bus_if.beat_tick), 32'd0);
    end
    chk("s2_done_hold", {bus_if.ibeat, 23'd0, bus_if.done}, {8'd3, 23'd0, 1'b1});

    // 3: looping
    pulse_stop();
    chk("s3_stop_done", 32'(bus_if.done), 32'd0);
    bus_if.loop_en = 1'b1;
    pulse_play();
    chk("s3_done_clr", 32'(bus_if.done), 32'd0);
    for (int b = 1; b <= 5; b++) begin
      expect_beat("s3_loop", 10, 8'(b % 4));
      chk("s3_no_done", 32'(bus_if.done), 32'd0);
    end

    // 4: pause at cnt=4 on beat 1, resume finishes the partial beat
    step(4);
    pulse_pause();
    chk("s4_paused", 32'(bus_if.playing), 32'd0);
    for (int i = 0; i < 25; i++) begin
      step(1);
      chk("s4_frozen", {bus_if.ibeat, 23'd0, bus_if.beat_tick}, {8'd1, 24'd0});
    end
    pulse_play();
    chk("s4_resumed", 32'(bus_if.playing), 32'd1);
    expect_beat("s4_resume", 6, 8'd2);

    // 5: tempo changes apply from the next beat
    pulse_stop();
    pulse_play();
    step(3);
    bus_if.tempo = 2'b01;
    expect_beat("s5_b0_norm", 7, 8'd1);
    expect_beat("s5_fast", 5, 8'd2);
    step(2);
    bus_if.tempo = 2'b10;
    expect_beat("s5_fast_end", 3, 8'd3);
    expect_beat("s5_slow", 20, 8'd0);
    bus_if.tempo = 2'b00;

    // 6a: stop+pause+play together on a wrap edge at ibeat 2
    pulse_stop();
    bus_if.loop_en = 1'b0;
    pulse_play();
    step(20);
    chk("s6_at_b2", 32'(bus_if.ibeat), 32'd2);
    step(9);
    bus_if.stop = 1'b1; bus_if.pause = 1'b1; bus_if.play = 1'b1;
    step(1);
    bus_if.stop = 1'b0; bus_if.pause = 1'b0; bus_if.play = 1'b0;
    chk("s6_all_ibeat", 32'(bus_if.ibeat),     32'd0);
    chk("s6_all_tick",  32'(bus_if.beat_tick), 32'd0);
    chk("s6_all_idle",  32'(bus_if.playing),   32'd0);
    step(15);
    chk("s6_idle_stays", {bus_if.ibeat, 22'd0, bus_if.playing, bus_if.beat_tick}, 32'd0);

    // 6b: reset in the middle of PAUSE clears the partial beat
    pulse_play();
    step(12);
    pulse_pause();
    chk("s6_pause_ibeat", 32'(bus_if.ibeat), 32'd1);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("s6_rst_outs", {bus_if.ibeat, 21'd0, bus_if.beat_tick, bus_if.playing, bus_if.done}, 32'd0);
    pulse_play();
    expect_beat("s6_post_rst", 10, 8'd1);

    // Pause on the wrap cycle: tick deferred to first PLAY cycle after resume
    step(9);
    pulse_pause();
    chk("wrap_pause_tick",  32'(bus_if.beat_tick), 32'd0);
    chk("wrap_pause_ibeat", 32'(bus_if.ibeat),     32'd1);
    step(4);
    pulse_play();
    chk("wrap_resume_edge", 32'(bus_if.beat_tick), 32'd0);
    step(1);
    chk("wrap_resume_tick", 32'(bus_if.beat_tick), 32'd1);
    chk("wrap_resume_beat", 32'(bus_if.ibeat),     32'd2);

    // Reverse playback (ignored unless the feature is built in)
    pulse_stop();
    bus_if.reverse = 1'b1;
    bus_if.loop_en = 1'b1;
    pulse_play();
`ifdef REVERSE_EN
    chk("rev_start", 32'(bus_if.ibeat), 32'd3);
    expect_beat("rev_b2", 10, 8'd2);
    expect_beat("rev_b1", 10, 8'd1);
    expect_beat("rev_b0", 10, 8'd0);
    expect_beat("rev_wrap", 10, 8'd3);
`else
    chk("rev_ignored_start", 32'(bus_if.ibeat), 32'd0);
    expect_beat("rev_ignored_b1", 10, 8'd1);
    expect_beat("rev_ignored_b2", 10, 8'd2);
`endif
    bus_if.reverse = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
Beat-index sequencer that sits directly upstream of the Music tone ROM. It replaces the gated beat-clock + PlayerCtrl pair with a single-clock block that derives the beat period internally. It emits the current beat index (ibeat) plus a one-cycle beat strobe and adds play/pause/stop, loop and tempo control, all in the system clock domain.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BEAT_FREQ, 8, beats per second at normal tempo (one beat = 0.125 s)
BEAT_LEN, 128, beats in the song; legal range 2..256

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset (reset==0 at a posedge resets the block)
play  input  1  one-cycle command pulse: start or resume
pause  input  1  one-cycle command pulse: freeze playback
stop  input  1  one-cycle command pulse: abort and rewind
loop_en  input  1  level: 1 = wrap to beat 0 at the end of the song, 0 = stop at the end
tempo  input  2  level: 00/11 normal, 01 fast (x2), 10 slow (x0.5)
reverse  input  1  level: backward playback (only honoured with REVERSE_EN)
ibeat  output  8  current beat index, to Music.ibeatNum
beat_tick  output  1  one-cycle pulse on every ibeat advance
playing  output  1  1 while in PLAY
done  output  1  1 while in DONE

Behaviour:
- All outputs are registered. Commands and level inputs sampled at a posedge take effect at that edge; outputs change on the same edge (visible the following cycle).
- Reset: state=IDLE, ibeat=0, beat_tick=0, playing=0, done=0, divider cnt=0, tempo_l=normal. Reset overrides everything, including mid-beat or mid-PAUSE.
- Period P = CLK_FREQ/BEAT_FREQ, integer divide. Current period Pc is P (normal), P/2 (fast) or 2P (slow), chosen from tempo_l. cnt width is sized for 2P.
- tempo_l loads from tempo on entry to PLAY from IDLE/DONE and at every cnt wrap. A tempo change mid-beat therefore applies from the next beat.
- States: IDLE, PLAY, PAUSE, DONE.
- Command priority when several are asserted together: stop > pause > play.
- IDLE: play -> PLAY with ibeat=0 and cnt=0. pause and stop are no-ops.
- PLAY:
  - cnt increments each cycle.
  - When cnt==Pc-1: cnt<=0, beat_tick=1 for that one cycle, then the index advances.
  - Advance when ibeat<BEAT_LEN-1: ibeat+1.
  - Advance when ibeat==BEAT_LEN-1: if loop_en=1, ibeat=0 and stay in PLAY; else -> DONE with ibeat held at BEAT_LEN-1 and no wrap.
  - Beat 0 lasts a full Pc after start. The first tick occurs Pc cycles after the play edge.
- PAUSE: cnt and ibeat frozen, beat_tick=0. play -> PLAY resuming the partial beat, so the remaining cycles equal Pc-cnt.
- DONE: done=1. play -> PLAY with ibeat=0, cnt=0 and done cleared.
- stop in PLAY, PAUSE or DONE -> IDLE, ibeat=0, cnt=0, beat_tick=0.
- pause in PLAY -> PAUSE. If pause coincides with a wrap cycle, pause wins: no tick, cnt holds at Pc-1, and the tick fires on the first PLAY cycle after resume.
- play while in PLAY is ignored. A stop or pause edge always suppresses beat_tick on that edge.
- playing = (state==PLAY); done = (state==DONE).

Optional Feature:
REVERSE_EN
- Defined:
  - While reverse=1 in PLAY, advance decrements ibeat.
  - At ibeat==0 it wraps to BEAT_LEN-1 if loop_en=1; else it goes to DONE holding 0.
  - play from IDLE/DONE with reverse=1 starts at ibeat=BEAT_LEN-1.
  - reverse is sampled at each advance.
- Undefined: the reverse input is ignored and direction is always forward. The port remains present so top-level wiring is unchanged.

Test Plan:
All scenarios use CLK_FREQ=80, BEAT_FREQ=8 (P=10) and BEAT_LEN=4.
1. Hold reset=0 for 3 cycles, then release -> ibeat=0, playing=0, done=0, beat_tick=0; with no commands the outputs stay unchanged for 50 cycles.
2. play pulse, loop_en=0, tempo=00 -> beat_tick every 10 cycles; ibeat goes 0,1,2,3; at cycle 40 done=1 and playing=0 with ibeat held at 3; no further ticks.
3. loop_en=1, play -> ibeat sequence 0,1,2,3,0,1 at 10-cycle spacing; done stays 0.
4. Playing with cnt=4 on beat 1: pause, wait 25 cycles, play -> ibeat stays 1 throughout the pause; the next tick comes exactly 6 cycles after resume.
5. Set tempo=01 mid-beat 0 -> beat 0 still lasts 10 cycles, later beats last 5. Then tempo=10 -> 20-cycle beats starting from the next beat.
6. Assert stop, pause and play in the same cycle while playing ibeat=2 -> IDLE, ibeat=0, no tick. Also assert reset=0 mid-PAUSE -> all outputs return to reset values. With REVERSE_EN defined, reverse=1, loop_en=1 and play -> ibeat sequence 3,2,1,0,3.
